// File: rtl/fetch_stage.sv
// Fetch stage of the RV64 pipeline: owns the PC, issues single-outstanding IMEM reads and loads the
// DE latches, with a one-entry skid buffer for responses that arrive while decode is stalled.
`timescale 1ns/1ps
module fetch_stage #(
  parameter int                 XLEN     = 64,
  parameter logic [XLEN-1:0]    RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            ld_de_i,
  input  logic            v_de_br_stall_i,
  input  logic            v_agex_br_stall_i,
  input  logic            v_mem_br_stall_i,
  input  logic            mem_br_taken_i,
  input  logic [XLEN-1:0] mem_target_i,
  output logic [XLEN-1:0] de_npc_o,
  output logic [31:0]     de_ir_o,
  output logic            de_v_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] FOUR       = XLEN'(4);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic            buf_v_q, buf_v_d;
  logic [31:0]     buf_ir_q, buf_ir_d;
  logic [XLEN-1:0] buf_npc_q, buf_npc_d;
  logic            de_v_q, de_v_d;
  logic [31:0]     de_ir_q, de_ir_d;
  logic [XLEN-1:0] de_npc_q, de_npc_d;

  logic            br_stall;
  logic            redirect;
  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] pc_plus4;
  logic            resp_ok;
  logic            live_to_de;
  logic            to_buf;

  assign br_stall       = v_de_br_stall_i | v_agex_br_stall_i | v_mem_br_stall_i;
  assign redirect       = mem_br_taken_i;
  assign target_aligned = mem_target_i & ALIGN_MASK;
  assign pc_plus4       = pc_q + FOUR;

  // A response is usable only if nothing (redirect or unresolved branch) kills it this cycle.
  assign resp_ok    = (state_q == S_REQ) && imem_ready_i && !redirect && !br_stall;
  assign live_to_de = resp_ok && ld_de_i && !buf_v_q;
  assign to_buf     = resp_ok && !live_to_de;

  assign imem_req_o  = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr_o = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign de_npc_o    = de_npc_q;
  assign de_ir_o     = de_ir_q;
  assign de_v_o      = de_v_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d = target_aligned;
        end else if (!br_stall && !buf_v_q) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_ready_i) begin
          if (redirect) begin
            pc_d    = target_aligned;
            state_d = S_IDLE;
          end else if (br_stall) begin
            state_d = S_IDLE;
          end else begin
            pc_d    = pc_plus4;
            state_d = live_to_de ? S_REQ : S_IDLE;
          end
        end else if (redirect) begin
          // The in-flight address must stay on the bus until IMEM answers it.
          pc_d        = target_aligned;
          drop_addr_d = pc_q;
          state_d     = S_DROP;
        end
      end
      S_DROP: begin
        if (redirect) pc_d = target_aligned;
        if (imem_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    buf_v_d   = buf_v_q;
    buf_ir_d  = buf_ir_q;
    buf_npc_d = buf_npc_q;
    de_v_d    = de_v_q;
    de_ir_d   = de_ir_q;
    de_npc_d  = de_npc_q;
    if (redirect) begin
      buf_v_d = 1'b0;
    end else begin
      if (ld_de_i && buf_v_q) buf_v_d = 1'b0;
      if (to_buf) begin
        buf_v_d   = 1'b1;
        buf_ir_d  = imem_rdata_i;
        buf_npc_d = pc_plus4;
      end
    end
    // Bubbles leave IR/NPC untouched; only the valid bit drops.
    if (ld_de_i) begin
      de_v_d = 1'b0;
      if (!redirect) begin
        if (buf_v_q) begin
          de_v_d   = 1'b1;
          de_ir_d  = buf_ir_q;
          de_npc_d = buf_npc_q;
        end else if (live_to_de) begin
          de_v_d   = 1'b1;
          de_ir_d  = imem_rdata_i;
          de_npc_d = pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC & ALIGN_MASK;
      drop_addr_q <= '0;
      buf_v_q     <= 1'b0;
      buf_ir_q    <= '0;
      buf_npc_q   <= '0;
      de_v_q      <= 1'b0;
      de_ir_q     <= '0;
      de_npc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      buf_v_q     <= buf_v_d;
      buf_ir_q    <= buf_ir_d;
      buf_npc_q   <= buf_npc_d;
      de_v_q      <= de_v_d;
      de_ir_q     <= de_ir_d;
      de_npc_q    <= de_npc_d;
    end
  end

endmodule
